// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the downstream decoder:
// opcode constants, fetch FSM encoding, FIFO entry layout and redirect-target helpers.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] pc4_hi, input logic [25:0] idx);
    return {pc4_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Fetch buffer of {pc, instr} entries. When empty the head output keeps showing
// the last entry that was at the head, so the decoder-facing word/pc hold steady.
module instr_fetch_unit_fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  fetch_entry_t  r_hold;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_DEPTH);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = o_empty ? r_hold : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Remember what the decoder last saw so the outputs hold once the buffer drains.
  always_ff @(posedge clk) begin
    if (reset)         r_hold <= '0;
    else if (!o_empty) r_hold <= r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs one outstanding imem read at a
// time, buffers returned words and redirects on decoder branch/jump with flush.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        dobranch,
  input  logic        dojump
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic [31:0]  r_addr;
  logic [31:0]  w_addr_nxt;
  logic [31:0]  w_pc4;
  logic [31:0]  w_target;
  logic         w_consume;
  logic         w_redirect;
  logic         w_req;
  logic         w_push;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  assign instr_valid  = ~w_empty;
  assign instr        = w_head.instr;
  assign instr_pc     = w_head.pc;
  assign w_consume    = instr_valid & instr_ready;
  assign w_redirect   = w_consume & (dobranch | dojump);
  assign w_pc4        = instr_pc + 32'd4;
  assign w_target     = dojump ? jump_target(w_pc4[31:28], instr[25:0])
                               : branch_target(w_pc4, instr[15:0]);
  assign w_push_entry = '{pc: r_addr, instr: imem_rdata};
  // The address latched at issue stays on the bus for the whole transaction.
  assign imem_addr    = (r_state == RUN) ? r_fetch_pc : r_addr;
  assign imem_req     = w_req & ~reset;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    w_req          = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      RUN: begin
        w_req = ~w_full & ~w_redirect;
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
        end else if (!w_full) begin
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = RUN;
        end
      end
      WAIT: begin
        w_req = 1'b1;
        if (w_redirect) begin
          // The in-flight word is wrong-path: drop it now or wait it out in DROP.
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = imem_ack ? RUN : DROP;
        end else if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_addr + 32'd4;
          w_state_nxt    = RUN;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DROP: begin
        w_req = 1'b1;
        if (w_redirect) w_fetch_pc_nxt = w_target;
        else            w_fetch_pc_nxt = r_fetch_pc;
        if (imem_ack) w_state_nxt = RUN;
        else          w_state_nxt = DROP;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  instr_fetch_unit_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_consume),
    .i_flush (w_redirect),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
